// File: rtl/idm_access_arbiter.sv
// Two-master arbiter (CPU, debug/loader) in front of a single-port 64x16 instruction/data memory.
// Optional grant/conflict statistics counters are enabled with `define IDM_ARB_STATS_EN.
module idm_access_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int DEPTH    = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef IDM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   cpu_grant_cnt,
  output logic [15:0]   dbg_grant_cnt,
  output logic [15:0]   conflict_cnt,
`endif
  output logic          addr_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CPU_OWN = 2'd1,
    S_DBG_OWN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d, hold_base;
  logic            cpu_sel, dbg_sel, keep_owner, other_req;
  logic            gnt_any, sel_we, in_range;
  logic [AW-1:0]   sel_addr, addr_hold_q;
  logic [DW-1:0]   sel_wdata, wdata_hold_q;
  logic            cpu_rvalid_q, dbg_rvalid_q, addr_err_q;
  logic [DW-1:0]   cpu_rdata_q, dbg_rdata_q;

  // Selection: the current owner keeps priority; in IDLE or CPU_OWN the CPU wins ties.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    cpu_sel = 1'b0;
    dbg_sel = 1'b0;
    if (state_q == S_DBG_OWN) begin
      if (dbg_req)      dbg_sel = 1'b1;
      else if (cpu_req) cpu_sel = 1'b1;
    end else begin
      if (cpu_req)      cpu_sel = 1'b1;
      else if (dbg_req) dbg_sel = 1'b1;
    end
  end

  // NOTE: grants are combinational, so they are gated by rst_n to cancel an access during reset.
  assign cpu_gnt = cpu_sel & rst_n;
  assign dbg_gnt = dbg_sel & rst_n;
  assign gnt_any = cpu_gnt | dbg_gnt;

  // Hold counter restarts whenever ownership changes hands within the cycle.
  always_comb begin
    keep_owner = (cpu_sel && state_q == S_CPU_OWN) || (dbg_sel && state_q == S_DBG_OWN);
    other_req  = (cpu_sel & dbg_req) | (dbg_sel & cpu_req);
    hold_base  = keep_owner ? hold_q : '0;
    hold_d     = '0;
    state_d    = S_IDLE;
    if (cpu_sel)      state_d = S_CPU_OWN;
    else if (dbg_sel) state_d = S_DBG_OWN;
    if (other_req) begin
      if (hold_base < HOLD_LAST)  hold_d  = hold_base + HW'(1);
      else if (dbg_sel && dbg_lock) hold_d = HOLD_MAX;
      else                        state_d = cpu_sel ? S_DBG_OWN : S_CPU_OWN;
    end
  end

  assign sel_we    = cpu_sel ? cpu_we    : dbg_we;
  assign sel_addr  = cpu_sel ? cpu_addr  : dbg_addr;
  assign sel_wdata = cpu_sel ? cpu_wdata : dbg_wdata;
  assign in_range  = {1'b0, sel_addr} < DEPTH_LIM;

  assign mem_we    = gnt_any & sel_we & in_range;
  assign mem_addr  = gnt_any ? sel_addr  : addr_hold_q;
  assign mem_wdata = gnt_any ? sel_wdata : wdata_hold_q;

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign addr_err   = addr_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      hold_q       <= hold_d;
      if (gnt_any) begin
        addr_hold_q  <= sel_addr;
        wdata_hold_q <= sel_wdata;
      end
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= in_range ? mem_rdata : '0;
      if (dbg_gnt && !dbg_we) dbg_rdata_q <= in_range ? mem_rdata : '0;
      addr_err_q   <= gnt_any & ~in_range;
    end
  end

`ifdef IDM_ARB_STATS_EN
  logic [15:0] cpu_cnt_q, dbg_cnt_q, conf_cnt_q;

  assign cpu_grant_cnt = cpu_cnt_q;
  assign dbg_grant_cnt = dbg_cnt_q;
  assign conflict_cnt  = conf_cnt_q;

  // Saturating counters; a clear request overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt_q  <= '0;
      dbg_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else if (stats_clr) begin
      cpu_cnt_q  <= '0;
      dbg_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (cpu_gnt && cpu_cnt_q != 16'hFFFF)            cpu_cnt_q  <= cpu_cnt_q + 16'd1;
      if (dbg_gnt && dbg_cnt_q != 16'hFFFF)            dbg_cnt_q  <= dbg_cnt_q + 16'd1;
      if (cpu_req && dbg_req && conf_cnt_q != 16'hFFFF) conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idm_access_arbiter.sv
// Self-checking bench for idm_access_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of ownership, hold limits and memory contents.
module tb_idm_access_arbiter;

  localparam int DEPTH    = 64;
  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [15:0] dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we, addr_err;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef IDM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] cpu_grant_cnt, dbg_grant_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idm_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef IDM_ARB_STATS_EN
    .stats_clr(stats_clr), .cpu_grant_cnt(cpu_grant_cnt), .dbg_grant_cnt(dbg_grant_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .addr_err(addr_err)
  );

  // Memory environment: combinational read, write at the clock edge, garbage outside the array.
  logic [15:0] mem [DEPTH] = '{default: '0};
  assign mem_rdata = (mem_addr < 16'(DEPTH)) ? mem[mem_addr[5:0]] : 16'hDEAD;
  always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    tick();
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_owner, m_streak, n_owner, n_streak;   // owner: 0 none, 1 cpu, 2 dbg
  logic        e_cpu_gnt, e_dbg_gnt, e_mem_we;
  logic [15:0] e_mem_addr, e_mem_wdata;
  logic        e_cpu_rvalid, e_dbg_rvalid, e_addr_err, e_cpu_known, e_dbg_known;
  logic [15:0] e_cpu_rdata, e_dbg_rdata;
  logic        n_cpu_rvalid, n_dbg_rvalid, n_addr_err, n_cpu_known, n_dbg_known;
  logic [15:0] n_cpu_rdata, n_dbg_rdata;
  logic [15:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  bit          w_pend;
  int          w_idx;
  logic [15:0] w_data;

  task automatic model_reset();
    m_owner = 0; m_streak = 0;
    e_cpu_gnt = 0; e_dbg_gnt = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    e_cpu_rvalid = 0; e_dbg_rvalid = 0; e_addr_err = 0; e_cpu_known = 1; e_dbg_known = 1;
    e_cpu_rdata = '0; e_dbg_rdata = '0; w_pend = 0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 0;
  endtask

  task automatic model_eval();
    int win, s;
    logic we;
    logic [15:0] a, d, rd;
    bit inr, kn, waiting;
    if (m_owner == 2) win = dbg_req ? 2 : (cpu_req ? 1 : 0);
    else              win = cpu_req ? 1 : (dbg_req ? 2 : 0);
    we = (win == 1) ? cpu_we : dbg_we;
    a  = (win == 1) ? cpu_addr : dbg_addr;
    d  = (win == 1) ? cpu_wdata : dbg_wdata;
    inr = (a < 16'(DEPTH));
    e_cpu_gnt = (win == 1);
    e_dbg_gnt = (win == 2);
    e_mem_we  = (win != 0) && we && inr;
    if (win != 0) begin e_mem_addr = a; e_mem_wdata = d; end
    w_pend = e_mem_we; w_idx = int'(a[5:0]); w_data = d;
    if (!inr) begin rd = '0; kn = 1; end
    else begin rd = ref_mem[a[5:0]]; kn = ref_known[a[5:0]]; end
    n_cpu_rvalid = (win == 1) && !we;
    n_dbg_rvalid = (win == 2) && !we;
    n_addr_err   = (win != 0) && !inr;
    n_cpu_rdata = n_cpu_rvalid ? rd : e_cpu_rdata;  n_cpu_known = n_cpu_rvalid ? kn : e_cpu_known;
    n_dbg_rdata = n_dbg_rvalid ? rd : e_dbg_rdata;  n_dbg_known = n_dbg_rvalid ? kn : e_dbg_known;
    // Consecutive-grant streak while the other side waits; a new owner starts from zero.
    waiting = (win == 1 && dbg_req) || (win == 2 && cpu_req);
    s = (win == m_owner) ? m_streak : 0;
    s = waiting ? s + 1 : 0;
    n_owner = win;
    if (win == 2 && dbg_lock) begin
      if (s > MAX_HOLD) s = MAX_HOLD;
    end else if (s >= MAX_HOLD) begin
      n_owner = 3 - win;
      s = 0;
    end
    n_streak = s;
  endtask

  task automatic model_advance();
    if (w_pend) begin ref_mem[w_idx] = w_data; ref_known[w_idx] = 1; end
    e_cpu_rvalid = n_cpu_rvalid; e_dbg_rvalid = n_dbg_rvalid; e_addr_err = n_addr_err;
    e_cpu_rdata = n_cpu_rdata; e_cpu_known = n_cpu_known;
    e_dbg_rdata = n_dbg_rdata; e_dbg_known = n_dbg_known;
    m_owner = n_owner; m_streak = n_streak;
  endtask

  task automatic pick(output logic r, output logic w, output logic [15:0] a, output logic [15:0] d);
    int sel;
    r = ($urandom_range(0, 99) < 80);
    w = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 9);
    if (sel == 0)      a = 16'($urandom_range(64, 400));
    else if (sel == 1) a = 16'($urandom_range(16, 63));
    else               a = 16'($urandom_range(0, 15));
    d = 16'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'd3; cpu_wdata = 16'h1111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'd4; dbg_wdata = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin errors++;
      $display("FAIL reset_gnt cpu=%b dbg=%b expected 0/0", cpu_gnt, dbg_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
    checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || addr_err !== 1'b0) begin errors++;
      $display("FAIL reset_flags rvalid=%b/%b addr_err=%b expected 0", cpu_rvalid, dbg_rvalid, addr_err); end
    checks++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_data rdata=%h/%h mem_addr=%h mem_wdata=%h expected 0",
                         cpu_rdata, dbg_rdata, mem_addr, mem_wdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_we !== 1'b1) begin errors++;
      $display("FAIL reset_tie cpu=%b dbg=%b we=%b expected 1/0/1", cpu_gnt, dbg_gnt, mem_we); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_midaccess cpu=%b dbg=%b we=%b expected 0/0/0", cpu_gnt, dbg_gnt, mem_we); end
    cpu_req = 0; dbg_req = 0;
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_write_read();
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'd5; dbg_wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'd5 || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL wr_dbg gnt=%b we=%b addr=%h data=%h expected 1/1/0005/beef",
                         dbg_gnt, mem_we, mem_addr, mem_wdata); end
    tick();
    dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'd5;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++;
      $display("FAIL rd_cpu_gnt gnt=%b we=%b dbg_rvalid=%b expected 1/0/0", cpu_gnt, mem_we, dbg_rvalid); end
    tick();
    cpu_req = 0;
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin errors++;
      $display("FAIL rd_cpu_data rvalid=%b rdata=%h expected 1/beef", cpu_rvalid, cpu_rdata); end
    checks++; if (cpu_gnt !== 1'b0 || mem_addr !== 16'd5) begin errors++;
      $display("FAIL idle_hold gnt=%b mem_addr=%h expected 0/0005", cpu_gnt, mem_addr); end
    tick();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL rvalid_pulse got %b expected 0", cpu_rvalid); end
    settle();
  endtask

  task automatic test_hold();
    bit exp_cpu;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'd2;
    for (int i = 0; i <= 2 * MAX_HOLD; i++) begin
      exp_cpu = ((i / MAX_HOLD) % 2) == 0;
      @(negedge clk);
      checks++; if (cpu_gnt !== exp_cpu || dbg_gnt !== !exp_cpu) begin errors++;
        $display("FAIL hold_cycle%0d cpu=%b dbg=%b expected %b/%b", i, cpu_gnt, dbg_gnt, exp_cpu, !exp_cpu); end
      tick();
    end
    settle();
  endtask

  task automatic test_lock();
    bit found;
    int wait_n;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'd9; dbg_lock = 1;
    @(negedge clk);
    checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL lock_start dbg_gnt=%b expected 1", dbg_gnt); end
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'd10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1) begin errors++;
        $display("FAIL lock_cycle%0d cpu=%b dbg=%b expected 0/1", i, cpu_gnt, dbg_gnt); end
      tick();
    end
    dbg_lock = 0;
    found = 0; wait_n = -1;
    for (int n = 0; n <= MAX_HOLD; n++) begin
      @(negedge clk);
      if (cpu_gnt === 1'b1) begin found = 1; wait_n = n; break; end
      tick();
    end
    checks++; if (!found) begin errors++;
      $display("FAIL unlock_grant cpu_gnt not seen within %0d cycles (got cycle %0d)", MAX_HOLD, wait_n); end
    tick();
    settle();
  endtask

  task automatic test_range();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'd64; cpu_wdata = 16'h1234;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd64) begin errors++;
      $display("FAIL oob_write gnt=%b we=%b addr=%h expected 1/0/0040", cpu_gnt, mem_we, mem_addr); end
    tick();
    cpu_we = 0; cpu_addr = 16'd70;
    @(negedge clk);
    checks++; if (addr_err !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL oob_write_err addr_err=%b rvalid=%b expected 1/0", addr_err, cpu_rvalid); end
    tick();
    cpu_req = 0;
    @(negedge clk);
    checks++; if (addr_err !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0) begin errors++;
      $display("FAIL oob_read err=%b rvalid=%b rdata=%h expected 1/1/0000", addr_err, cpu_rvalid, cpu_rdata); end
    tick();
    @(negedge clk);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oob_err_pulse got %b expected 0", addr_err); end
    settle();
  endtask

`ifdef IDM_ARB_STATS_EN
  task automatic test_stats();
    stats_clr = 1; tick(); stats_clr = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'd1; dbg_req = 1; dbg_we = 0; dbg_addr = 16'd2;
    repeat (3) tick();
    cpu_req = 0; tick();
    cpu_req = 1; tick();
    cpu_req = 0; dbg_req = 0;
    @(negedge clk);
    checks++; if (cpu_grant_cnt !== 16'd3 || dbg_grant_cnt !== 16'd2 || conflict_cnt !== 16'd4) begin errors++;
      $display("FAIL stats_counts %0d/%0d/%0d expected 3/2/4", cpu_grant_cnt, dbg_grant_cnt, conflict_cnt); end
    tick();
    stats_clr = 1; cpu_req = 1; dbg_req = 1; tick(); stats_clr = 0; cpu_req = 0; dbg_req = 0;
    @(negedge clk);
    checks++; if (cpu_grant_cnt !== 16'd0 || dbg_grant_cnt !== 16'd0 || conflict_cnt !== 16'd0) begin errors++;
      $display("FAIL stats_clear %0d/%0d/%0d expected 0/0/0", cpu_grant_cnt, dbg_grant_cnt, conflict_cnt); end
    settle();
  endtask
`endif

  task automatic test_random();
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req || e_cpu_gnt) pick(cpu_req, cpu_we, cpu_addr, cpu_wdata);
      if (!dbg_req || e_dbg_gnt) pick(dbg_req, dbg_we, dbg_addr, dbg_wdata);
      if ($urandom_range(0, 29) == 0) dbg_lock = ~dbg_lock;
      @(negedge clk);
      model_eval();
      checks++; if (cpu_gnt !== e_cpu_gnt || dbg_gnt !== e_dbg_gnt) begin errors++;
        $display("FAIL rnd_gnt cyc%0d cpu=%b dbg=%b expected %b/%b", i, cpu_gnt, dbg_gnt, e_cpu_gnt, e_dbg_gnt); end
      checks++; if (mem_we !== e_mem_we) begin errors++;
        $display("FAIL rnd_mem_we cyc%0d got %b expected %b", i, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr || mem_wdata !== e_mem_wdata) begin errors++;
        $display("FAIL rnd_mem_bus cyc%0d addr=%h data=%h expected %h/%h", i, mem_addr, mem_wdata,
                 e_mem_addr, e_mem_wdata); end
      checks++; if (cpu_rvalid !== e_cpu_rvalid || dbg_rvalid !== e_dbg_rvalid) begin errors++;
        $display("FAIL rnd_rvalid cyc%0d cpu=%b dbg=%b expected %b/%b", i, cpu_rvalid, dbg_rvalid,
                 e_cpu_rvalid, e_dbg_rvalid); end
      checks++; if (addr_err !== e_addr_err) begin errors++;
        $display("FAIL rnd_addr_err cyc%0d got %b expected %b", i, addr_err, e_addr_err); end
      if (e_cpu_rvalid && e_cpu_known) begin
        checks++; if (cpu_rdata !== e_cpu_rdata) begin errors++;
          $display("FAIL rnd_cpu_rdata cyc%0d got %h expected %h", i, cpu_rdata, e_cpu_rdata); end
      end
      if (e_dbg_rvalid && e_dbg_known) begin
        checks++; if (dbg_rdata !== e_dbg_rdata) begin errors++;
          $display("FAIL rnd_dbg_rdata cyc%0d got %h expected %h", i, dbg_rdata, e_dbg_rdata); end
      end
      tick();
      model_advance();
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_lock();
    test_range();
`ifdef IDM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
